// File: rtl/platform_spawner_if.sv
// Scroll-request and platform read-port bundle between the view logic,
// the renderer/collision logic and platform_spawner.
interface platform_spawner_if #(
  parameter int NUM_BLOCKS = 8
) ();
  localparam int IDX_W = $clog2(NUM_BLOCKS);

  logic             newView;
  logic [31:0]      minY;
  logic [IDX_W-1:0] rd_idx;
  logic [15:0]      rd_x;
  logic [31:0]      rd_y;
  logic             scan_busy;
  logic             respawned;
  logic             scan_done;

  modport master (
    output newView, minY, rd_idx,
    input  rd_x, rd_y, scan_busy, respawned, scan_done
  );

  modport slave (
    input  newView, minY, rd_idx,
    output rd_x, rd_y, scan_busy, respawned, scan_done
  );
endinterface

// File: rtl/platform_spawner.sv
// Platform pool: on each scroll request, recycles every platform below the view
// bottom to just above the topmost one, at a pseudo-random x.
module platform_spawner #(
  parameter int          SCREEN_WIDTH  = 400,
  parameter int          SCREEN_HEIGHT = 700,
  parameter int          BLOCK_WIDTH   = 40,
  parameter int          BLOCK_HEIGHT  = 5,
  parameter int          NUM_BLOCKS    = 8,
  parameter int          BLOCK_SPACING = 80,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic               clk,
  input logic               reset,
  platform_spawner_if.slave bus
);
  localparam int               IDX_W     = $clog2(NUM_BLOCKS);
  localparam int               X_RANGE   = SCREEN_WIDTH - BLOCK_WIDTH;
  localparam logic [9:0]       X_RANGE_W = 10'(X_RANGE);
  localparam logic [15:0]      LFSR_MASK = 16'hB400;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [31:0]      SPACING   = 32'(BLOCK_SPACING);

  // SCREEN_HEIGHT/BLOCK_HEIGHT only exist for parameter-list compatibility.
  if (NUM_BLOCKS < 2 || LFSR_SEED == 16'h0 || X_RANGE < 256 || X_RANGE > 512 ||
      SCREEN_HEIGHT < 1 || BLOCK_HEIGHT < 1) begin : g_bad_params
    $error("platform_spawner: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_pending;
  logic [31:0]      r_min_lat;
  logic [31:0]      r_top_y;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_x [NUM_BLOCKS];
  logic [31:0]      r_y [NUM_BLOCKS];
  logic             r_scan_busy, r_respawned, r_scan_done;

  logic             w_last, w_recycle, w_rescan;
  logic [15:0]      w_lfsr_next;
  logic [9:0]       w_r9;
  logic [15:0]      w_rx;

  assign w_last      = (r_idx == LAST_IDX);
  assign w_recycle   = (r_state == S_SCAN) && (r_y[r_idx] < r_min_lat);
  assign w_rescan    = w_last && (r_pending || bus.newView);
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
  assign w_r9        = {1'b0, r_lfsr[8:0]};

  // A single conditional subtract suffices because 511 < 2 * X_RANGE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_rx = 16'(w_r9);
    if (w_r9 >= X_RANGE_W) w_rx = 16'(w_r9 - X_RANGE_W);
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.newView) w_state_next = S_SCAN;
      S_SCAN:  if (w_last && !w_rescan) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_min_lat   <= '0;
      r_top_y     <= 32'((NUM_BLOCKS - 1) * BLOCK_SPACING);
      r_lfsr      <= LFSR_SEED;
      r_scan_busy <= 1'b0;
      r_respawned <= 1'b0;
      r_scan_done <= 1'b0;
      // NOTE: the pool is a flop array, not a RAM, so it can and must take its
      // staircase layout on reset; a mid-scan reset then leaves no partial update.
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_y[i] <= 32'(i * BLOCK_SPACING);
        r_x[i] <= 16'((i * 3 * BLOCK_WIDTH) % X_RANGE);
      end
    end else begin
      r_lfsr      <= w_lfsr_next;
      r_scan_busy <= (w_state_next == S_SCAN);
      r_respawned <= w_recycle;
      r_scan_done <= (r_state == S_SCAN) && w_last;

      unique case (r_state)
        S_IDLE: begin
          if (bus.newView) begin
            r_min_lat <= bus.minY;
            r_idx     <= '0;
          end
        end
        S_SCAN: begin
          if (w_recycle) begin
            r_y[r_idx] <= r_top_y + SPACING;
            r_x[r_idx] <= w_rx;
            r_top_y    <= r_top_y + SPACING;
          end
          if (w_last) begin
            r_idx     <= '0;
            r_pending <= 1'b0;
            if (w_rescan) r_min_lat <= bus.minY;
          end else begin
            r_idx <= r_idx + 1'b1;
            // Requests during a scan coalesce into a single rescan.
            if (bus.newView) r_pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rd_x = '0;
    bus.rd_y = '0;
    if (int'(bus.rd_idx) < NUM_BLOCKS) begin
      bus.rd_x = r_x[bus.rd_idx];
      bus.rd_y = r_y[bus.rd_idx];
    end
  end

  assign bus.scan_busy = r_scan_busy;
  assign bus.respawned = r_respawned;
  assign bus.scan_done = r_scan_done;
endmodule

// File: tb/tb_platform_spawner.sv
// Scoreboarded bench for platform_spawner: per-scan respawn/busy expectations
// are queued at issue and checked by a monitor on every scan_done pulse.
module tb_platform_spawner;
  localparam int N  = 8;
  localparam int SP = 80;
  localparam int XR = 360;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  platform_spawner_if #(.NUM_BLOCKS(N)) bus ();

  platform_spawner #(
    .SCREEN_WIDTH(400), .SCREEN_HEIGHT(700), .BLOCK_WIDTH(40), .BLOCK_HEIGHT(5),
    .NUM_BLOCKS(N), .BLOCK_SPACING(SP), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int resp;
    int busy;
  } exp_t;
  exp_t exp_q[$];
  int   mon_resp = 0;
  int   mon_busy = 0;

  // Monitor: respawns in the done cycle belong to the finishing scan, busy in
  // the done cycle belongs to a following rescan.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      mon_resp = 0;
      mon_busy = 0;
    end else begin
      if (bus.respawned) mon_resp++;
      if (bus.scan_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_scan_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("respawn_count", mon_resp, e.resp);
          check("busy_cycles", mon_busy, e.busy);
        end
        mon_resp = 0;
        mon_busy = 0;
      end
      if (bus.scan_busy) mon_busy++;
    end
  end

  // Reference pool model.
  logic [31:0] ym [N];
  logic [31:0] top_m;
  logic [15:0] rxs [N];
  logic [31:0] rys [N];
  logic [15:0] pxs [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) ym[i] = 32'(i * SP);
    top_m = 32'((N - 1) * SP);
  endtask

  task automatic model_scan(input logic [31:0] my, output int cnt, output logic [N-1:0] mask);
    cnt  = 0;
    mask = '0;
    for (int i = 0; i < N; i++) begin
      if (ym[i] < my) begin
        top_m   = top_m + 32'(SP);
        ym[i]   = top_m;
        mask[i] = 1'b1;
        cnt++;
      end
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 3'(i);
      #1;
      rxs[i] = bus.rd_x;
      rys[i] = bus.rd_y;
    end
  endtask

  task automatic snapshot_x();
    read_all();
    for (int i = 0; i < N; i++) pxs[i] = rxs[i];
  endtask

  task automatic verify_slots(input string tag, input logic [N-1:0] mask, input bit detail);
    bit ok_y = 1'b1, ok_x = 1'b1, ok_d = 1'b1;
    read_all();
    for (int i = 0; i < N; i++) begin
      if (detail) begin
        check($sformatf("%s_y%0d", tag, i), rys[i], ym[i]);
        if (mask[i]) check($sformatf("%s_xrange%0d", tag, i), rxs[i] < 16'(XR), 1);
        else         check($sformatf("%s_xkeep%0d", tag, i), rxs[i], pxs[i]);
      end else begin
        if (rys[i] != ym[i]) ok_y = 1'b0;
        if (mask[i] ? (rxs[i] >= 16'(XR)) : (rxs[i] != pxs[i])) ok_x = 1'b0;
        for (int j = 0; j < i; j++) if (rys[i] == rys[j]) ok_d = 1'b0;
        if (rys[i] % 80 != 0) ok_d = 1'b0;
      end
    end
    if (!detail) begin
      check({tag, "_y"}, ok_y, 1);
      check({tag, "_x"}, ok_x, 1);
      check({tag, "_distinct"}, ok_d, 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [15:0] xr [4];
    xr = '{16'd0, 16'd120, 16'd240, 16'd0};
    check({tag, "_busy"}, bus.scan_busy, 0);
    check({tag, "_done"}, bus.scan_done, 0);
    check({tag, "_resp"}, bus.respawned, 0);
    read_all();
    for (int i = 0; i < N; i++) check($sformatf("%s_y%0d", tag, i), rys[i], 32'(i * 80));
    for (int i = 0; i < 4; i++) check($sformatf("%s_x%0d", tag, i), rxs[i], xr[i]);
  endtask

  task automatic do_scan(input logic [31:0] my, output logic [N-1:0] mask);
    int cnt, n;
    @(negedge clk);
    bus.minY    = my;
    bus.newView = 1'b1;
    @(posedge clk);
    model_scan(my, cnt, mask);
    exp_q.push_back('{cnt, N});
    @(negedge clk);
    bus.newView = 1'b0;
    n = 0;
    while (!bus.scan_done && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, N);
    check("busy_low_at_done", bus.scan_busy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] mask;
    int           cnt;
    reset       = 1'b0;
    bus.newView = 1'b0;
    bus.minY    = '0;
    bus.rd_idx  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b1;

    // Single recycle: slot 0 moves above the top platform (560 + 80).
    snapshot_x();
    do_scan(32'd1, mask);
    check("single_mask", mask, 8'b0000_0001);
    @(negedge clk);
    check("done_one_cycle", bus.scan_done, 0);
    verify_slots("single", mask, 1'b1);
    check("single_slot0_y", rys[0], 640);

    // Two recycles: slots 1 and 2 stack to 720 and 800.
    snapshot_x();
    do_scan(32'd161, mask);
    verify_slots("multi", mask, 1'b1);
    check("multi_slot1_y", rys[1], 720);
    check("multi_slot2_y", rys[2], 800);

    // Coalescing: three requests collapse into one immediate rescan.
    snapshot_x();
    @(negedge clk);
    bus.minY    = '0;
    bus.newView = 1'b1;
    @(posedge clk);
    model_scan('0, cnt, mask);
    model_scan('0, cnt, mask);
    exp_q.push_back('{0, N});
    exp_q.push_back('{0, N});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.newView = 1'b0;
    repeat (6) @(negedge clk);
    check("coal_done1", bus.scan_done, 1);
    check("coal_rescan_busy", bus.scan_busy, 1);
    repeat (8) @(negedge clk);
    check("coal_done2", bus.scan_done, 1);
    check("coal_idle_busy", bus.scan_busy, 0);
    @(negedge clk);
    check("coal_done_clear", bus.scan_done, 0);
    check("coal_queue", exp_q.size(), 0);
    verify_slots("coal", '0, 1'b1);

    // Reset asserted just after E3 of an all-recycling scan.
    @(negedge clk);
    bus.minY    = 32'd1000;
    bus.newView = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.newView = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    model_reset();
    #1 check_reset_state("midrst");
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_resp", mon_resp, 0);
    check("midrst_idle", bus.scan_busy, 0);

    // top_y restored: slot 0 again lands at 640.
    snapshot_x();
    do_scan(32'd1, mask);
    verify_slots("post_rst", mask, 1'b1);
    check("post_rst_slot0_y", rys[0], 640);

    // Long run with a rising view bottom.
    for (int k = 0; k < 2000; k++) begin
      snapshot_x();
      do_scan(32'((k + 1) * 80), mask);
      verify_slots("xrun", mask, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
